// File: rtl/ex_stage_pipe.sv
// Execute stage: forwarding, ALU, branch resolution with registered redirect, and an
// optional iterative shift-add multiplier, wrapped in valid/ready handshakes on both sides.
module ex_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int MUL_EN = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic [RA_W-1:0] in_rd,
    input  logic [3:0]      in_alu_op,
    input  logic            in_alu_src,
    input  logic            in_branch,
    input  logic [2:0]      in_br_cond,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    input  logic            in_mem_to_reg,
    input  logic            fwd_mem_valid,
    input  logic            fwd_wb_valid,
    input  logic [RA_W-1:0] fwd_mem_rd,
    input  logic [RA_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_write_data,
    output logic [RA_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_mem_to_reg,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic {IDLE, MUL} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] wdata;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
    } entry_t;

    state_t          state, state_nxt;
    entry_t          cur, out_q, hold_q;
    logic            hold_taken;
    logic [XLEN-1:0] hold_target;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd, op_b, alu_res, br_target;
    logic [XLEN-1:0] mul_a, mul_b, acc;
    logic [CNT_W-1:0] cnt;
    logic            br_cond_ok, br_taken, is_mul, accept, mul_done;

    // MEM beats WB; x0 is hard zero in the register file and never forwarded.
    always_comb begin
        rs1_fwd = in_rs1_val;
        rs2_fwd = in_rs2_val;
        if (in_rs1 != '0 && fwd_mem_valid && fwd_mem_rd == in_rs1)    rs1_fwd = fwd_mem_data;
        else if (in_rs1 != '0 && fwd_wb_valid && fwd_wb_rd == in_rs1) rs1_fwd = fwd_wb_data;
        if (in_rs2 != '0 && fwd_mem_valid && fwd_mem_rd == in_rs2)    rs2_fwd = fwd_mem_data;
        else if (in_rs2 != '0 && fwd_wb_valid && fwd_wb_rd == in_rs2) rs2_fwd = fwd_wb_data;
    end

    assign op_b = in_alu_src ? in_imm : rs2_fwd;

    always_comb begin
        alu_res = '0;
        case (in_alu_op)
            4'd0: alu_res = rs1_fwd + op_b;
            4'd1: alu_res = rs1_fwd - op_b;
            4'd2: alu_res = rs1_fwd & op_b;
            4'd3: alu_res = rs1_fwd | op_b;
            4'd4: alu_res = rs1_fwd ^ op_b;
            4'd5: alu_res = rs1_fwd << op_b[SH_W-1:0];
            4'd6: alu_res = rs1_fwd >> op_b[SH_W-1:0];
            4'd7: alu_res = $unsigned($signed(rs1_fwd) >>> op_b[SH_W-1:0]);
            4'd8: alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_fwd) < $signed(op_b)};
            4'd9: alu_res = {{(XLEN-1){1'b0}}, rs1_fwd < op_b};
            default: alu_res = '0;
        endcase
    end

    // Branch compares the register operands even when B is the immediate.
    always_comb begin
        br_cond_ok = 1'b0;
        case (in_br_cond)
            3'b000: br_cond_ok = rs1_fwd == rs2_fwd;
            3'b001: br_cond_ok = rs1_fwd != rs2_fwd;
            3'b100: br_cond_ok = $signed(rs1_fwd) < $signed(rs2_fwd);
            3'b101: br_cond_ok = $signed(rs1_fwd) >= $signed(rs2_fwd);
            3'b110: br_cond_ok = rs1_fwd < rs2_fwd;
            3'b111: br_cond_ok = rs1_fwd >= rs2_fwd;
            default: br_cond_ok = 1'b0;
        endcase
    end

    assign br_taken  = in_branch && br_cond_ok;
    assign br_target = in_pc + in_imm;
    assign is_mul    = (MUL_EN != 0) && (in_alu_op == 4'd10);
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_done  = (state == MUL) && (cnt == '0) && (!out_valid || out_ready);
    assign busy      = (state == MUL);

    assign cur = '{pc: in_pc, result: alu_res, wdata: rs2_fwd, rd: in_rd,
                   reg_write: in_reg_write, mem_read: in_mem_read,
                   mem_write: in_mem_write, mem_to_reg: in_mem_to_reg};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mul) state_nxt = MUL;
            MUL:     if (mul_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q          <= '0;
            out_valid      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            hold_q         <= '0;
            hold_taken     <= 1'b0;
            hold_target    <= '0;
            mul_a          <= '0;
            mul_b          <= '0;
            acc            <= '0;
            cnt            <= '0;
        end else if (flush) begin
            out_valid      <= 1'b0;
            redirect_valid <= 1'b0;
            cnt            <= '0;
        end else begin
            redirect_valid <= 1'b0;
            if (accept && !is_mul) begin
                out_q          <= cur;
                out_valid      <= 1'b1;
                redirect_valid <= br_taken;
                redirect_pc    <= br_target;
            end else if (mul_done) begin
                out_q          <= hold_q;
                out_q.result   <= acc;
                out_valid      <= 1'b1;
                redirect_valid <= hold_taken;
                redirect_pc    <= hold_target;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Shift-add multiplier: one partial product per cycle, LSB of B first.
            if (accept && is_mul) begin
                hold_q      <= cur;
                hold_taken  <= br_taken;
                hold_target <= br_target;
                mul_a       <= rs1_fwd;
                mul_b       <= op_b;
                acc         <= '0;
                cnt         <= CNT_W'(XLEN);
            end else if (state == MUL && cnt != '0) begin
                if (mul_b[0]) acc <= acc + mul_a;
                mul_a <= mul_a << 1;
                mul_b <= mul_b >> 1;
                cnt   <= cnt - 1'b1;
            end
        end
    end

    assign out_pc         = out_q.pc;
    assign out_alu_result = out_q.result;
    assign out_write_data = out_q.wdata;
    assign out_rd         = out_q.rd;
    assign out_reg_write  = out_q.reg_write;
    assign out_mem_read   = out_q.mem_read;
    assign out_mem_write  = out_q.mem_write;
    assign out_mem_to_reg = out_q.mem_to_reg;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: one instance with the multiplier, one without,
// sharing all inputs; expected values are hand-computed constants.
module tb_ex_stage_pipe;
    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1;
    logic [XLEN-1:0] in_pc = '0, in_rs1_val = '0, in_rs2_val = '0, in_imm = '0;
    logic [RA_W-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [3:0] in_alu_op = '0;
    logic in_alu_src = 1'b0, in_branch = 1'b0;
    logic [2:0] in_br_cond = '0;
    logic in_reg_write = 1'b0, in_mem_read = 1'b0, in_mem_write = 1'b0, in_mem_to_reg = 1'b0;
    logic fwd_mem_valid = 1'b0, fwd_wb_valid = 1'b0;
    logic [RA_W-1:0] fwd_mem_rd = '0, fwd_wb_rd = '0;
    logic [XLEN-1:0] fwd_mem_data = '0, fwd_wb_data = '0;

    logic in_ready, out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
    logic redirect_valid, busy;
    logic [XLEN-1:0] out_pc, out_alu_result, out_write_data, redirect_pc;
    logic [RA_W-1:0] out_rd;

    logic z_in_ready, z_out_valid, z_out_reg_write, z_out_mem_read, z_out_mem_write, z_out_mem_to_reg;
    logic z_redirect_valid, z_busy;
    logic [XLEN-1:0] z_out_pc, z_out_alu_result, z_out_write_data, z_redirect_pc;
    logic [RA_W-1:0] z_out_rd;

    int total = 0, fails = 0;

    always #5 clk = ~clk;

    ex_stage_pipe #(.XLEN(XLEN), .RA_W(RA_W), .MUL_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_op(in_alu_op),
        .in_alu_src(in_alu_src), .in_branch(in_branch), .in_br_cond(in_br_cond),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_mem_to_reg(in_mem_to_reg), .fwd_mem_valid(fwd_mem_valid), .fwd_wb_valid(fwd_wb_valid),
        .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_data(fwd_wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_alu_result(out_alu_result), .out_write_data(out_write_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_mem_to_reg(out_mem_to_reg), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    ex_stage_pipe #(.XLEN(XLEN), .RA_W(RA_W), .MUL_EN(0)) dut_nomul (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_op(in_alu_op),
        .in_alu_src(in_alu_src), .in_branch(in_branch), .in_br_cond(in_br_cond),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_mem_to_reg(in_mem_to_reg), .fwd_mem_valid(fwd_mem_valid), .fwd_wb_valid(fwd_wb_valid),
        .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_data(fwd_wb_data), .out_valid(z_out_valid), .out_ready(out_ready), .out_pc(z_out_pc),
        .out_alu_result(z_out_alu_result), .out_write_data(z_out_write_data), .out_rd(z_out_rd),
        .out_reg_write(z_out_reg_write), .out_mem_read(z_out_mem_read),
        .out_mem_write(z_out_mem_write), .out_mem_to_reg(z_out_mem_to_reg),
        .redirect_valid(z_redirect_valid), .redirect_pc(z_redirect_pc), .busy(z_busy)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [3:0] alu, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] imm, input logic src);
        in_valid = 1'b1; in_alu_op = alu; in_rs1_val = a; in_rs2_val = b;
        in_imm = imm; in_alu_src = src; in_branch = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        in_rs1 = 5'd1; in_rs2 = 5'd2;
        repeat (2) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_alu_result, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        tick();

        // ADD, then three back-to-back forwarding cases
        op(4'd0, 32'd5, 32'd7, 32'd0, 1'b0);
        in_pc = 32'h40; in_rd = 5'd3; in_reg_write = 1'b1;
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", out_alu_result, 32'd12);
        chk("add_pc", out_pc, 32'h40);
        chk("add_rd", 32'(out_rd), 32'd3);
        chk("add_regwrite", 32'(out_reg_write), 32'd1);

        op(4'd1, 32'h99, 32'd1, 32'd0, 1'b0);
        in_rs1 = 5'd3; in_rs2 = 5'd4;
        fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'h10;
        fwd_wb_valid  = 1'b1; fwd_wb_rd  = 5'd3; fwd_wb_data  = 32'h20;
        tick();
        chk("fwd_mem", out_alu_result, 32'h0F);
        chk("fwd_wdata", out_write_data, 32'd1);
        chk("fwd_b2b_valid", 32'(out_valid), 32'd1);
        fwd_mem_valid = 1'b0;
        tick();
        chk("fwd_wb", out_alu_result, 32'h1F);
        in_rs1 = 5'd0; fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
        tick();
        chk("fwd_x0", out_alu_result, 32'h98);
        fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0; in_rs1 = 5'd1; in_rs2 = 5'd2;

        op(4'd5, 32'd1, 32'd0, 32'd35, 1'b1);
        tick();
        chk("sll_imm", out_alu_result, 32'd8);
        op(4'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b1);
        tick();
        chk("sra", out_alu_result, 32'hF800_0000);
        op(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        tick();
        chk("slt", out_alu_result, 32'd1);
        op(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        tick();
        chk("sltu", out_alu_result, 32'd0);

        // BLT taken, then BLTU not taken
        op(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0);
        in_branch = 1'b1; in_br_cond = 3'b100; in_pc = 32'h100;
        tick();
        chk("blt_redirect", 32'(redirect_valid), 32'd1);
        chk("blt_target", redirect_pc, 32'h120);
        chk("blt_out_pc", out_pc, 32'h100);
        in_valid = 1'b0;
        tick();
        chk("blt_pulse_end", 32'(redirect_valid), 32'd0);
        op(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0);
        in_branch = 1'b1; in_br_cond = 3'b110;
        tick();
        chk("bltu_valid", 32'(out_valid), 32'd1);
        chk("bltu_no_redirect", 32'(redirect_valid), 32'd0);
        in_valid = 1'b0; in_branch = 1'b0;
        tick();

        // MUL: N+1 without multiplier, N+XLEN+1 with
        op(4'd10, 32'h1234, 32'h10, 32'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("nomul_valid", 32'(z_out_valid), 32'd1);
        chk("nomul_result", z_out_alu_result, 32'd0);
        chk("mul_busy", 32'(busy), 32'd1);
        chk("mul_in_ready", 32'(in_ready), 32'd0);
        chk("mul_out_valid_early", 32'(out_valid), 32'd0);
        repeat (32) tick();
        chk("mul_busy_late", 32'(busy), 32'd1);
        chk("mul_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("mul_valid", 32'(out_valid), 32'd1);
        chk("mul_result", out_alu_result, 32'h12340);
        chk("mul_idle", 32'(busy), 32'd0);
        tick();
        chk("mul_drain", 32'(out_valid), 32'd0);

        // Backpressure: first entry held, second waits, then loads with no bubble
        out_ready = 1'b0;
        op(4'd0, 32'd1, 32'd1, 32'd0, 1'b0);
        in_rd = 5'd6;
        tick();
        op(4'd0, 32'd2, 32'd2, 32'd0, 1'b0);
        in_rd = 5'd7;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_result", out_alu_result, 32'd2);
            chk("bp_hold_rd", 32'(out_rd), 32'd6);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_result", out_alu_result, 32'd4);
        chk("bp_next_rd", 32'(out_rd), 32'd7);
        tick();
        chk("bp_no_dup", 32'(out_valid), 32'd0);

        // Flush mid-multiply
        op(4'd10, 32'h1234, 32'h10, 32'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_mul_busy", 32'(busy), 32'd0);
        chk("flush_mul_valid", 32'(out_valid), 32'd0);
        chk("flush_mul_ready", 32'(in_ready), 32'd1);
        repeat (30) tick();
        chk("flush_mul_no_result", 32'(out_valid), 32'd0);

        // Flush in the branch-accept cycle
        op(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0);
        in_branch = 1'b1; in_br_cond = 3'b100;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; in_branch = 1'b0;
        chk("flush_br_redirect", 32'(redirect_valid), 32'd0);
        chk("flush_br_valid", 32'(out_valid), 32'd0);
        tick();
        chk("flush_br_redirect_late", 32'(redirect_valid), 32'd0);

        // Reset mid-multiply
        op(4'd10, 32'h1234, 32'h10, 32'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("rstmul_busy", 32'(busy), 32'd0);
        chk("rstmul_valid", 32'(out_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (40) tick();
        chk("rstmul_no_result", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
